// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and address helpers for the in-place radix-2 DIT FFT controller.
// addr_pair_t and the helpers are sized from FFT_LOG2N; the top's LOG2N must match it.
package fft_ctrl_pkg;

  localparam int unsigned FFT_LOG2N = 3;
  localparam int unsigned FFT_AW    = FFT_LOG2N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_e;

  typedef struct packed {
    logic [FFT_AW-1:0] a;
    logic [FFT_AW-1:0] b;
  } addr_pair_t;

  // Upper/lower leg addresses of butterfly j in stage s.
  function automatic addr_pair_t bf_addr(input logic [FFT_AW-1:0] s,
                                         input logic [FFT_AW-2:0] j);
    logic [FFT_AW-1:0] jj, span, lo;
    addr_pair_t p;
    jj   = {1'b0, j};
    span = FFT_AW'(1) << s;
    lo   = jj & (span - FFT_AW'(1));
    p.a  = ((jj >> s) << (s + FFT_AW'(1))) | lo;
    p.b  = p.a + span;
    return p;
  endfunction

  function automatic logic [FFT_AW-2:0] bf_tw(input logic [FFT_AW-1:0] s,
                                              input logic [FFT_AW-2:0] j);
    logic [FFT_AW-1:0] jj, span;
    jj   = {1'b0, j};
    span = FFT_AW'(1) << s;
    return (FFT_AW-1)'((jj & (span - FFT_AW'(1))) << (FFT_AW'(FFT_AW - 1) - s));
  endfunction

endpackage

// File: rtl/wb_addr_fifo.sv
// Synchronous FIFO holding write-back address pairs; first-word fall-through head.
module wb_addr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage/butterfly sequencer: issues reads, feeds the
// butterfly chain and writes each result back to the addresses it was read from.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N     = FFT_LOG2N,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             m_axis_tvalid_o,
  output logic             m_axis_tlast_o,
  input  logic             m_axis_tready_i,
  input  logic             s_axis_tvalid_i,
  input  logic             s_axis_tlast_i,
  output logic             s_axis_tready_o,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic [LOG2N-1:0] stage_o
);

  localparam int unsigned TW_AW = LOG2N - 1;
  localparam int unsigned CW    = $clog2(MAX_OUTST + 1);
  localparam logic [LOG2N-1:0] LAST_S = LOG2N'(LOG2N - 1);

  fsm_e             state_q;
  logic [LOG2N-1:0] s_q;
  logic [TW_AW-1:0] j_q;
  logic             busy_q, done_q, err_q, tvalid_q, tlast_q;

  logic             issue, pop, drained, last_j, last_s;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  addr_pair_t       rd_pair, wr_pair;
  logic             unused_tlast;

  assign unused_tlast = s_axis_tlast_i;

  assign rd_pair = bf_addr(s_q, j_q);
  assign last_j  = (j_q == '1);
  assign last_s  = (s_q == LAST_S);
  assign issue   = (state_q == RUN) && m_axis_tready_i && !fifo_full;
  assign pop     = s_axis_tvalid_i && !fifo_empty;
  // Counting the final pop lets the next stage read the cycle after the last write.
  assign drained = fifo_empty || (pop && fifo_count == CW'(1));

  assign rd_en_o         = issue;
  assign rd_addr_a_o     = issue ? rd_pair.a : '0;
  assign rd_addr_b_o     = issue ? rd_pair.b : '0;
  assign tw_addr_o       = issue ? bf_tw(s_q, j_q) : '0;
  assign wr_en_o         = pop;
  assign wr_addr_a_o     = pop ? wr_pair.a : '0;
  assign wr_addr_b_o     = pop ? wr_pair.b : '0;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign s_axis_tready_o = busy_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign stage_o         = s_q;

  wb_addr_fifo #(
    .DEPTH(MAX_OUTST),
    .T    (addr_pair_t)
  ) u_wb_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (issue),
    .data_i (rd_pair),
    .pop_i  (pop),
    .data_o (wr_pair),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      s_q      <= '0;
      j_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= issue;
      tlast_q  <= issue && last_j;
      done_q   <= 1'b0;
      if (s_axis_tvalid_i && fifo_empty) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            s_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (issue) begin
            j_q <= j_q + 1'b1;
            if (last_j) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            if (last_s) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              s_q     <= s_q + 1'b1;
              state_q <= RUN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
